// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer: issues one instruction fetch at a time, selects the next PC
// (correction > prediction > PC+4) and buffers returned instructions for decode.
module pc_seq_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            seq_correction_en_in,
    input  logic [XLEN-1:0] seq_correction_addr_in,
    input  logic            seq_prediction_en_in,
    input  logic [XLEN-1:0] seq_prediction_addr_in,
    output logic            seq_imem_req_out,
    output logic [XLEN-1:0] seq_imem_addr_out,
    input  logic            seq_imem_gnt_in,
    input  logic            seq_imem_valid_in,
    input  logic [XLEN-1:0] seq_imem_data_in,
    output logic            seq_inst_valid_out,
    input  logic            seq_inst_ready_in,
    output logic [XLEN-1:0] seq_inst_out,
    output logic [XLEN-1:0] seq_inst_pc_out,
    output logic            seq_inst_pred_out
);

    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic            req_reg;
    logic            squash_reg;
    logic            buf_valid_reg;
    logic [XLEN-1:0] buf_inst_reg;
    logic [XLEN-1:0] buf_pc_reg;
    logic            buf_pred_reg;
    logic [XLEN-1:0] skid_inst_reg;
    logic [XLEN-1:0] skid_pc_reg;
    logic            skid_pred_reg;

    logic            handshake;
    logic [XLEN-1:0] pc_next;

    assign handshake = buf_valid_reg & seq_inst_ready_in;
    // Prediction only matters for the instruction returning this cycle.
    assign pc_next   = seq_prediction_en_in ? seq_prediction_addr_in : pc_reg + XLEN'(4);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_ADDR;
            req_reg       <= 1'b0;
            squash_reg    <= 1'b0;
            buf_valid_reg <= 1'b0;
            buf_inst_reg  <= '0;
            buf_pc_reg    <= '0;
            buf_pred_reg  <= 1'b0;
            skid_inst_reg <= '0;
            skid_pc_reg   <= '0;
            skid_pred_reg <= 1'b0;
        end else begin
            if (handshake) begin
                buf_valid_reg <= 1'b0;
            end
            case (state_reg)
                BOOT: begin
                    if (seq_correction_en_in) begin
                        pc_reg <= seq_correction_addr_in;
                    end
                    state_reg <= REQ;
                    req_reg   <= 1'b1;
                end
                REQ: begin
                    if (seq_correction_en_in) begin
                        pc_reg        <= seq_correction_addr_in;
                        buf_valid_reg <= 1'b0;
                    end
                    if (seq_imem_gnt_in) begin
                        // A granted fetch of a now-stale address must be dropped on return.
                        squash_reg <= seq_correction_en_in;
                        state_reg  <= WAIT;
                        req_reg    <= 1'b0;
                    end
                end
                WAIT: begin
                    if (seq_correction_en_in) begin
                        pc_reg        <= seq_correction_addr_in;
                        buf_valid_reg <= 1'b0;
                        if (seq_imem_valid_in) begin
                            squash_reg <= 1'b0;
                            state_reg  <= REQ;
                            req_reg    <= 1'b1;
                        end else begin
                            squash_reg <= 1'b1;
                        end
                    end else if (seq_imem_valid_in) begin
                        if (squash_reg) begin
                            squash_reg <= 1'b0;
                            state_reg  <= REQ;
                            req_reg    <= 1'b1;
                        end else begin
                            pc_reg <= pc_next;
                            if (!buf_valid_reg || seq_inst_ready_in) begin
                                buf_valid_reg <= 1'b1;
                                buf_inst_reg  <= seq_imem_data_in;
                                buf_pc_reg    <= pc_reg;
                                buf_pred_reg  <= seq_prediction_en_in;
                                state_reg     <= REQ;
                                req_reg       <= 1'b1;
                            end else begin
                                skid_inst_reg <= seq_imem_data_in;
                                skid_pc_reg   <= pc_reg;
                                skid_pred_reg <= seq_prediction_en_in;
                                state_reg     <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    // The skid entry is implied by this state; leaving it empties the skid.
                    if (seq_correction_en_in) begin
                        pc_reg        <= seq_correction_addr_in;
                        buf_valid_reg <= 1'b0;
                        state_reg     <= REQ;
                        req_reg       <= 1'b1;
                    end else if (handshake) begin
                        buf_valid_reg <= 1'b1;
                        buf_inst_reg  <= skid_inst_reg;
                        buf_pc_reg    <= skid_pc_reg;
                        buf_pred_reg  <= skid_pred_reg;
                        state_reg     <= REQ;
                        req_reg       <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= BOOT;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign seq_imem_req_out   = req_reg;
    assign seq_imem_addr_out  = pc_reg;
    assign seq_inst_valid_out = buf_valid_reg;
    assign seq_inst_out       = buf_inst_reg;
    assign seq_inst_pc_out    = buf_pc_reg;
    assign seq_inst_pred_out  = buf_pred_reg;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: memory responses driven step by step, decode
// outputs checked against a queue of expected {inst, pc, pred} records.
module tb_pc_seq_ctrl;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } out_t;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        seq_correction_en_in = 1'b0;
    logic [31:0] seq_correction_addr_in = '0;
    logic        seq_prediction_en_in = 1'b0;
    logic [31:0] seq_prediction_addr_in = '0;
    logic        seq_imem_req_out;
    logic [31:0] seq_imem_addr_out;
    logic        seq_imem_gnt_in = 1'b0;
    logic        seq_imem_valid_in = 1'b0;
    logic [31:0] seq_imem_data_in = '0;
    logic        seq_inst_valid_out;
    logic        seq_inst_ready_in = 1'b1;
    logic [31:0] seq_inst_out;
    logic [31:0] seq_inst_pc_out;
    logic        seq_inst_pred_out;

    int   checks   = 0;
    int   failures = 0;
    out_t exp_q[$];

    pc_seq_ctrl dut (
        .clock_in               (clock_in),
        .reset_in               (reset_in),
        .seq_correction_en_in   (seq_correction_en_in),
        .seq_correction_addr_in (seq_correction_addr_in),
        .seq_prediction_en_in   (seq_prediction_en_in),
        .seq_prediction_addr_in (seq_prediction_addr_in),
        .seq_imem_req_out       (seq_imem_req_out),
        .seq_imem_addr_out      (seq_imem_addr_out),
        .seq_imem_gnt_in        (seq_imem_gnt_in),
        .seq_imem_valid_in      (seq_imem_valid_in),
        .seq_imem_data_in       (seq_imem_data_in),
        .seq_inst_valid_out     (seq_inst_valid_out),
        .seq_inst_ready_in      (seq_inst_ready_in),
        .seq_inst_out           (seq_inst_out),
        .seq_inst_pc_out        (seq_inst_pc_out),
        .seq_inst_pred_out      (seq_inst_pred_out)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scores any decode handshake about to happen on the coming edge, then advances.
    task automatic tick();
        out_t obs;
        out_t exp;
        if (seq_inst_valid_out === 1'b1 && seq_inst_ready_in === 1'b1) begin
            obs = {seq_inst_out, seq_inst_pc_out, seq_inst_pred_out};
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL out_unexpected observed pc=%h inst=%h expected no output", obs.pc, obs.inst);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                checks++;
                assert (obs === exp) else begin
                    failures++;
                    $error("FAIL out_data observed inst=%h pc=%h pred=%b expected inst=%h pc=%h pred=%b",
                           obs.inst, obs.pc, obs.pred, exp.inst, exp.pc, exp.pred);
                end
            end
        end
        @(posedge clock_in);
        #1;
    endtask

    task automatic check_next_req(input logic [31:0] a);
        int n = 0;
        while (seq_imem_req_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(seq_imem_req_out), 32'd1);
        chk("req_addr", seq_imem_addr_out, a);
    endtask

    task automatic req_grant(input logic [31:0] a);
        check_next_req(a);
        seq_imem_gnt_in = 1'b1;
        tick();
        seq_imem_gnt_in = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic pe, input logic [31:0] pa);
        req_grant(a);
        seq_imem_valid_in      = 1'b1;
        seq_imem_data_in       = data_of(a);
        seq_prediction_en_in   = pe;
        seq_prediction_addr_in = pa;
        exp_q.push_back({data_of(a), a, pe});
        tick();
        seq_imem_valid_in    = 1'b0;
        seq_prediction_en_in = 1'b0;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        #1;
        chk("rst_req", 32'(seq_imem_req_out), 32'd0);
        chk("rst_addr", seq_imem_addr_out, 32'h0);
        chk("rst_valid", 32'(seq_inst_valid_out), 32'd0);
        chk("rst_inst", seq_inst_out, 32'h0);
        chk("rst_pc", seq_inst_pc_out, 32'h0);
        chk("rst_pred", 32'(seq_inst_pred_out), 32'd0);
        exp_q.delete();
        @(posedge clock_in);
        #1;
        reset_in = 1'b0;
    endtask

    task automatic drain_and_check();
        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        @(posedge clock_in);
        #1;

        // Plain sequential fetch
        do_reset();
        do_fetch(32'h0, 1'b0, 32'h0);
        do_fetch(32'h4, 1'b0, 32'h0);
        do_fetch(32'h8, 1'b0, 32'h0);
        check_next_req(32'hC);
        drain_and_check();

        // Predicted-taken redirect
        do_reset();
        do_fetch(32'h0, 1'b0, 32'h0);
        do_fetch(32'h4, 1'b1, 32'h100);
        do_fetch(32'h100, 1'b0, 32'h0);
        check_next_req(32'h104);
        drain_and_check();

        // Correction while waiting: returned data dropped
        do_reset();
        do_fetch(32'h0, 1'b0, 32'h0);
        req_grant(32'h4);
        seq_correction_en_in   = 1'b1;
        seq_correction_addr_in = 32'h200;
        tick();
        seq_correction_en_in = 1'b0;
        seq_imem_valid_in    = 1'b1;
        seq_imem_data_in     = data_of(32'h4);
        tick();
        seq_imem_valid_in = 1'b0;
        chk("squash_valid", 32'(seq_inst_valid_out), 32'd0);
        do_fetch(32'h200, 1'b0, 32'h0);
        drain_and_check();

        // Decode stall: second return goes to skid, block holds
        do_reset();
        seq_inst_ready_in = 1'b0;
        do_fetch(32'h0, 1'b0, 32'h0);
        do_fetch(32'h4, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", 32'(seq_imem_req_out), 32'd0);
            chk("hold_valid", 32'(seq_inst_valid_out), 32'd1);
            chk("hold_pc", seq_inst_pc_out, 32'h0);
            chk("hold_inst", seq_inst_out, data_of(32'h0));
            tick();
        end
        seq_inst_ready_in = 1'b1;
        check_next_req(32'h8);
        drain_and_check();

        // Correction coincident with returned data carrying a prediction
        do_reset();
        do_fetch(32'h0, 1'b0, 32'h0);
        req_grant(32'h4);
        seq_correction_en_in   = 1'b1;
        seq_correction_addr_in = 32'h300;
        seq_imem_valid_in      = 1'b1;
        seq_imem_data_in       = data_of(32'h4);
        seq_prediction_en_in   = 1'b1;
        seq_prediction_addr_in = 32'h500;
        tick();
        seq_correction_en_in = 1'b0;
        seq_imem_valid_in    = 1'b0;
        seq_prediction_en_in = 1'b0;
        chk("coinc_valid", 32'(seq_inst_valid_out), 32'd0);
        req_grant(32'h300);

        // Reset with a fetch outstanding, stray valid during boot, then wrap
        do_reset();
        seq_correction_en_in   = 1'b1;
        seq_correction_addr_in = 32'hFFFF_FFFC;
        seq_imem_valid_in      = 1'b1;
        seq_imem_data_in       = 32'hDEAD_BEEF;
        tick();
        seq_correction_en_in = 1'b0;
        seq_imem_valid_in    = 1'b0;
        chk("boot_valid", 32'(seq_inst_valid_out), 32'd0);
        do_fetch(32'hFFFF_FFFC, 1'b0, 32'h0);
        check_next_req(32'h0);
        drain_and_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
